// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped branch target buffer with saturating direction counters
//
// Purpose: fetch gets a zero-latency next-PC prediction from registered table
// state; execute reports resolved control instructions, which update the table
// on the next edge, raise a combinational flush request and supply the refetch PC.
// Saturating lookup and mispredict counters support performance runs.
//
// Ports:
//   CLK, nRST            clock (rising edge), asynchronous active-low reset
//   clear                synchronous invalidate of every entry (stats kept)
//   lookup_en/lookup_pc  fetch lookup valid and PC
//   pred_hit/pred_taken  lookup result: tag hit, predicted taken
//   pred_pc              predicted next PC
//   update_en/update_*   resolved instruction from execute (pc, outcome, target)
//   ex_pred_taken/pc     prediction carried down the pipe with that instruction
//   mispredict           flush request
//   correct_pc           PC to refetch
//   stat_lookups         saturating count of lookups
//   stat_mispredicts     saturating count of mispredicts
module branch_predictor_btb #(
  parameter int ENTRIES  = 16,
  parameter int PC_W     = 32,
  parameter int CTR_BITS = 2,
  parameter int CTR_INIT = 1,
  parameter int STAT_W   = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              clear,
  input  logic              lookup_en,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              pred_hit,
  output logic              pred_taken,
  output logic [PC_W-1:0]   pred_pc,
  input  logic              update_en,
  input  logic [PC_W-1:0]   update_pc,
  input  logic              update_taken,
  input  logic [PC_W-1:0]   update_target,
  input  logic              ex_pred_taken,
  input  logic [PC_W-1:0]   ex_pred_pc,
  output logic              mispredict,
  output logic [PC_W-1:0]   correct_pc,
  output logic [STAT_W-1:0] stat_lookups,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = PC_W - IDX_W - 2;

  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(CTR_INIT);
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_BITS'(1) << (CTR_BITS - 1);
  localparam logic [STAT_W-1:0]   STAT_MAX = {STAT_W{1'b1}};

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [PC_W-1:0]     target_q [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];

  logic [STAT_W-1:0] lookups_q;
  logic [STAT_W-1:0] mispredicts_q;

  // Word-aligned PCs: bits [1:0] never take part in indexing or tagging.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[PC_W-1:IDX_W+2];
  assign up_idx = update_pc[IDX_W+1:2];
  assign up_tag = update_pc[PC_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Prediction reads registered state only, so a same-cycle update to the
  // same index is not visible until the following cycle.
  always_comb begin
    pred_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken = pred_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_pc    = pred_taken ? target_q[lk_idx] : lookup_pc + PC_W'(4);
  end

  // A taken branch is only correctly predicted if the carried target matched too.
  always_comb begin
    mispredict = update_en &&
                 ((update_taken != ex_pred_taken) ||
                  (update_taken && (update_target != ex_pred_pc)));
    correct_pc = update_taken ? update_target : update_pc + PC_W'(4);
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_RST;
      end
    end else if (clear) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_RST;
      end
    end else if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          target_q[up_idx] <= update_target;
          if (ctr_q[up_idx] != CTR_MAX) ctr_q[up_idx] <= ctr_q[up_idx] + CTR_BITS'(1);
        end else if (ctr_q[up_idx] != '0) begin
          ctr_q[up_idx] <= ctr_q[up_idx] - CTR_BITS'(1);
        end
      end else if (update_taken) begin
        // Direct-mapped: allocation simply evicts whatever aliases this index.
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= update_target;
        ctr_q[up_idx]    <= CTR_WEAK;
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      if (lookup_en && (lookups_q != STAT_MAX)) lookups_q <= lookups_q + STAT_W'(1);
      if (mispredict && (mispredicts_q != STAT_MAX)) mispredicts_q <= mispredicts_q + STAT_W'(1);
    end
  end

  assign stat_lookups     = lookups_q;
  assign stat_mispredicts = mispredicts_q;

endmodule

// File: doc/branch_predictor_btb.md
Name: branch_predictor_btb

Overview:
- Parametrised branch target buffer with per-entry saturating direction counters for the pipelined datapath.
- Fetch looks up PC every cycle and gets a predicted next PC combinationally.
- Execute reports resolved branches/jumps; the block updates its table, flags mispredictions and supplies the corrected PC for flush.
- Keeps saturating lookup/mispredict statistics for performance runs.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, >= 2
PC_W, 32, PC width in bits
CTR_BITS, 2, direction counter width, >= 1
CTR_INIT, 1, counter value at reset and on clear
STAT_W, 32, width of statistics counters

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  asynchronous active-low reset
clear  in  1  synchronous invalidate of all entries
lookup_en  in  1  fetch lookup valid (ihit)
lookup_pc  in  PC_W  fetch PC
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  hit and counter MSB set
pred_pc  out  PC_W  predicted next PC
update_en  in  1  EX stage resolving a control instruction this cycle
update_pc  in  PC_W  PC of resolved instruction
update_taken  in  1  actual outcome
update_target  in  PC_W  actual target
ex_pred_taken  in  1  prediction carried down the pipe with the instruction
ex_pred_pc  in  PC_W  predicted next PC carried down the pipe
mispredict  out  1  flush request
correct_pc  out  PC_W  PC to refetch on mispredict
stat_lookups  out  STAT_W  counted lookups
stat_mispredicts  out  STAT_W  counted mispredicts

Behaviour:
- IDX_W = log2(ENTRIES). index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. pc[1:0] is ignored.
- Each entry holds valid, tag, target and a CTR_BITS counter.
- Lookup is combinational from registered state:
  - pred_hit = valid & tag match.
  - pred_taken = pred_hit & ctr[MSB].
  - pred_pc = pred_taken ? target : lookup_pc+4, modulo 2^PC_W.
  - Outputs are valid regardless of lookup_en.
- Mispredict is combinational:
  - mispredict = update_en & (update_taken != ex_pred_taken | (update_taken & update_target != ex_pred_pc)).
  - correct_pc = update_taken ? update_target : update_pc+4. correct_pc is valid whenever update_en is high.
- Table update on the clock edge with update_en=1 and clear=0:
  - Hit, taken: counter increments, saturating at 2^CTR_BITS-1; target <= update_target.
  - Hit, not taken: counter decrements, saturating at 0; target unchanged.
  - Miss, taken: allocate, overwriting any aliasing entry. valid=1, tag, target, counter = 2^(CTR_BITS-1) (weakly taken).
  - Miss, not taken: no change.
- Same-cycle lookup and update to the same index: lookup returns the pre-update contents. No bypass. The write is visible from the next cycle.
- clear: on the next edge, all valid=0 and all counters=CTR_INIT. clear has priority over a simultaneous update. Statistics are kept.
- Statistics:
  - stat_lookups increments on each edge with lookup_en=1.
  - stat_mispredicts increments on each edge with mispredict=1.
  - Both saturate at all-ones and are not cleared by clear.
- Reset (nRST low, asynchronous): all valid=0, all counters=CTR_INIT, targets/tags=0, stats=0.
  - Outputs during reset: pred_hit=0, pred_taken=0, pred_pc=lookup_pc+4, stat_*=0.
  - mispredict/correct_pc follow their inputs combinationally.
  - Reset asserted mid-update discards the update.
- Latency: prediction 0 cycles; table and stat update 1 cycle.

Test Plan:
- After reset, lookup_pc=0x0000_0040 -> pred_hit=0, pred_taken=0, pred_pc=0x44; stats=0.
- Update pc=0x40, taken, target=0x100, ex_pred_taken=0, ex_pred_pc=0x44 -> mispredict=1, correct_pc=0x100 same cycle. Next cycle lookup 0x40 -> hit, taken, pred_pc=0x100; stat_mispredicts=1.
- Counter hysteresis on the 0x40 entry (starts weakly taken, CTR=2):
  - Two not-taken updates -> counter 0; lookup gives pred_taken=0, pred_pc=0x44.
  - Two more not-taken updates -> counter stays 0.
  - One taken update -> counter 1, still predicts not taken.
- Alias with ENTRIES=16: pc 0x40 and 0x80 share index 0. Allocate 0x40 taken, then 0x80 taken with target 0x200 -> lookup 0x40 misses, lookup 0x80 hits with pred_pc=0x200.
- Same-cycle lookup and update of 0x40 (allocation) -> that cycle pred_hit=0; next cycle pred_hit=1. clear together with an update -> all entries invalid next cycle, stats retained.
- Statistics saturation with STAT_W=4: 20 cycles of lookup_en=1 -> stat_lookups=15, no wrap. Assert nRST mid-run -> all stats read 0 immediately, without waiting for a clock edge.
